// File: rtl/vga_timing_out.sv
// 640x480@60 raster timing generator and VGA pin output stage.
// Counters feed the draw stage; its rgb returns and is aligned to sync.
module vga_timing_out #(
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_TOTAL  = 800,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 29,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_TOTAL  = 521,
  parameter logic        SYNC_POL = 1'b0,
  parameter int unsigned PIPE_DLY = 1
) (
  input  logic       clk_25,
  input  logic       rst_n,
  output logic [9:0] h_count,
  output logic [9:0] v_count,
  output logic       frame_start,
  input  logic [7:0] rgb_in,
  output logic       Hsync,
  output logic       Vsync,
  output logic [2:0] vga_red,
  output logic [2:0] vga_green,
  output logic [1:0] vga_blue
);

  localparam logic [9:0] L_H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] L_V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] L_HS     = 10'(H_SYNC);
  localparam logic [9:0] L_VS     = 10'(V_SYNC);
  localparam logic [9:0] L_HA_LO  = 10'(H_SYNC + H_BP);
  localparam logic [9:0] L_HA_HI  = 10'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0] L_VA_LO  = 10'(V_SYNC + V_BP);
  localparam logic [9:0] L_VA_HI  = 10'(V_SYNC + V_BP + V_ACTIVE);

  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
  } dec_t;

  logic [9:0] r_h;
  logic [9:0] r_v;
  logic       r_fs;
  logic [9:0] w_h_nxt;
  logic [9:0] w_v_nxt;
  logic       w_fs_nxt;
  dec_t       w_dec;
  dec_t       w_dly;
  logic       r_hsync;
  logic       r_vsync;
  logic [7:0] r_rgb;

  always_comb begin
    w_h_nxt = r_h + 10'd1;
    w_v_nxt = r_v;
    if (r_h == L_H_LAST) begin
      w_h_nxt = '0;
      w_v_nxt = (r_v == L_V_LAST) ? '0 : r_v + 10'd1;
    end
    w_fs_nxt = (w_h_nxt == '0) && (w_v_nxt == '0);
  end

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      r_h  <= '0;
      r_v  <= '0;
      r_fs <= 1'b0;
    end else begin
      r_h  <= w_h_nxt;
      r_v  <= w_v_nxt;
      r_fs <= w_fs_nxt;
    end
  end

  always_comb begin
    w_dec.hs  = r_h < L_HS;
    w_dec.vs  = r_v < L_VS;
    w_dec.act = (r_h >= L_HA_LO) && (r_h < L_HA_HI) &&
                (r_v >= L_VA_LO) && (r_v < L_VA_HI);
  end

  // decode is delayed to meet the draw stage's rgb latency
  if (PIPE_DLY == 0) begin : g_nodly
    assign w_dly = w_dec;
  end else begin : g_dly
    dec_t r_dly [PIPE_DLY];
    always_ff @(posedge clk_25 or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < int'(PIPE_DLY); i++)
          r_dly[i] <= '0;
      end else begin
        r_dly[0] <= w_dec;
        for (int i = 1; i < int'(PIPE_DLY); i++)
          r_dly[i] <= r_dly[i-1];
      end
    end
    assign w_dly = r_dly[PIPE_DLY-1];
  end

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      r_hsync <= ~SYNC_POL;
      r_vsync <= ~SYNC_POL;
      r_rgb   <= '0;
    end else begin
      r_hsync <= w_dly.hs ? SYNC_POL : ~SYNC_POL;
      r_vsync <= w_dly.vs ? SYNC_POL : ~SYNC_POL;
      r_rgb   <= w_dly.act ? rgb_in : 8'h00;
    end
  end

  assign h_count     = r_h;
  assign v_count     = r_v;
  assign frame_start = r_fs;
  assign Hsync       = r_hsync;
  assign Vsync       = r_vsync;
  assign vga_red     = r_rgb[7:5];
  assign vga_green   = r_rgb[4:2];
  assign vga_blue    = r_rgb[1:0];

endmodule

// File: doc/vga_timing_out.md
Name: vga_timing_out

Overview:
- 640x480@60 Hz raster timing generator plus output stage for the Nexys3 VGA path, clocked by the 25 MHz pixel clock.
- Produces the free-running h_count/v_count that drive the pixel-drawing stage.
- Takes that stage's registered 8-bit rgb back, aligns it with delayed sync/active decode, blanks it outside the active window, and drives the board's VGA pins.

Parameters:
- H_SYNC, 96, hsync pulse width in pixels
- H_BP, 48, horizontal back porch
- H_ACTIVE, 640, visible pixels per line
- H_TOTAL, 800, pixels per line, including front porch
- V_SYNC, 2, vsync pulse width in lines
- V_BP, 29, vertical back porch
- V_ACTIVE, 480, visible lines
- V_TOTAL, 521, lines per frame
- SYNC_POL, 0, asserted level of Hsync/Vsync (0 = negative)
- PIPE_DLY, 1, cycles from counter value to valid rgb_in (legal 0..4)

Ports:
- clk_25  in  1  25 MHz pixel clock
- rst_n  in  1  asynchronous active-low reset
- h_count  out  10  horizontal position, 0..H_TOTAL-1
- v_count  out  10  vertical position, 0..V_TOTAL-1
- frame_start  out  1  high for exactly the cycle where h_count=0 and v_count=0
- rgb_in  in  8  pixel from drawing stage, RRRGGGBB, valid PIPE_DLY cycles after its counters
- Hsync  out  1  horizontal sync to pin
- Vsync  out  1  vertical sync to pin
- vga_red  out  3  red pins
- vga_green  out  3  green pins
- vga_blue  out  2  blue pins

Behaviour:
- Reset (rst_n low, asynchronous, any time):
  - h_count=0, v_count=0, frame_start=0.
  - Hsync=Vsync=~SYNC_POL (deasserted); all colour outputs 0.
  - All delay-line stages hold sync-deasserted and active=0.
  - Release is synchronous to the next clk_25 edge; counting starts from 0,0.
- Counters, all registered:
  - h_count increments every cycle; at H_TOTAL-1 it wraps to 0.
  - v_count increments only in the cycle where h_count=H_TOTAL-1; at V_TOTAL-1 with h_count=H_TOTAL-1 it wraps to 0.
  - Both wrap in the same edge at end of frame (799,520 -> 0,0).
- frame_start is registered from the next-state decode, so it is high in the same cycle the counters read 0,0. It is not asserted on the first cycle after reset release.
- Decode, combinational from the current counters:
  - hs_a = h_count < H_SYNC
  - vs_a = v_count < V_SYNC
  - act = h_count in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) and v_count in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE). Defaults: h 144..783, v 31..510.
- Alignment:
  - hs_a, vs_a and act pass through a PIPE_DLY-deep shift register, then one output register.
  - rgb_in passes through the same output register only.
  - All pin outputs therefore lag the counters by exactly PIPE_DLY+1 cycles (2 at default). A counter value at edge t appears on the pins after edge t+PIPE_DLY+1.
  - PIPE_DLY=0: no delay line; decode goes straight to the output register.
- Output register:
  - Hsync = SYNC_POL when delayed hs_a, else ~SYNC_POL; same rule for Vsync.
  - If delayed act: vga_red=rgb_in[7:5], vga_green=rgb_in[4:2], vga_blue=rgb_in[1:0]. Otherwise all colour outputs are 0, regardless of rgb_in.
- No handshake: the counters never stall, and rgb_in is sampled every cycle unconditionally.
- Width rule: all comparisons are unsigned 10-bit. Parameter sums must not exceed 1023; there is no overflow handling beyond that.

Test Plan:
- Reset: hold rst_n=0 for 5 cycles, then release -> during reset h_count=v_count=0, Hsync=Vsync=1, colours 0, frame_start=0. First edge after release gives h_count=1. Assert rst_n mid-line at h=400, v=200 -> all outputs return to reset values immediately, without waiting for a clock edge.
- Line wrap: run to h_count=799, v_count=10 -> next cycle h_count=0, v_count=11. Over one line, Hsync is low for exactly 96 consecutive cycles, starting 2 cycles after h_count=0.
- Frame wrap: at h=799, v=520 -> next cycle 0,0 with frame_start=1 for 1 cycle. Vsync is low for exactly 1600 cycles per frame, and the frame period is 416800 cycles.
- Active gating: drive rgb_in=8'hFF constant -> pins read red=7, green=7, blue=3 only for counter positions h 144..783, v 31..510, each seen 2 cycles later. Pins read 0 at h=143 and at h=784 (same delay).
- Alignment: drive rgb_in = low 8 bits of h_count, delayed 1 cycle (a draw-stage model) -> at visible counter h=200 (8'hC8), the pins 2 cycles later read red=6, green=2, blue=0. Repeat with PIPE_DLY=3 and a 3-cycle model -> same pin values, now 4 cycles later.
- Colour split: hold rgb_in=8'hCE in the active region -> red=6, green=3, blue=2.
